// File: rtl/rbp_sample_player.sv
// Plays SDRAM-resident 16-bit samples through the rbp read-back port: clears the
// read pointer, prefetches words into a small FIFO and emits one per sample period.
module rbp_sample_player #(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned FIFO_AW = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [23:0]      play_len,
    input  logic [DIV_W-1:0] period,
    output logic             rbp_req,
    input  logic             rbp_ack,
    output logic             rbp_rst,
    output logic             rbp_dat,
    output logic [3:0]       rbp_cmd,
    input  logic [15:0]      rbp_data,
    output logic [15:0]      sample_out,
    output logic             sample_valid,
    output logic             playing,
    output logic             done,
    output logic             underrun,
    output logic             timeout_err
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned CNT_W = FIFO_AW + 1;
    localparam int unsigned LEN_W = 24;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLR     = 3'd1;
    localparam logic [2:0] S_CLR_REL = 3'd2;
    localparam logic [2:0] S_FETCH   = 3'd3;
    localparam logic [2:0] S_RD      = 3'd4;
    localparam logic [2:0] S_RD_REL  = 3'd5;
    localparam logic [2:0] S_ABORT   = 3'd6;

    logic [2:0]         state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d, fetched_q, fetched_d, played_q, played_d;
    logic [DIV_W-1:0]   per_q, per_d, tmr_q, tmr_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   fifo_cnt_q;
    logic [15:0]        mem_q [DEPTH];
    logic               req_q, req_d, rst_q, rst_d, playing_q, playing_d, done_q, done_d;
    logic               valid_q, valid_d, underrun_q, underrun_d, to_err_q, to_err_d;
    logic [3:0]         cmd_q, cmd_d;
    logic [15:0]        sample_q, sample_d;
    logic               push, pop, flush, tick, in_phase, in_run;

    assign rbp_req      = req_q;
    assign rbp_rst      = rst_q;
    assign rbp_dat      = 1'b0;
    assign rbp_cmd      = cmd_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign playing      = playing_q;
    assign done         = done_q;
    assign underrun     = underrun_q;
    assign timeout_err  = to_err_q;

    assign in_phase = (state_q == S_CLR) || (state_q == S_CLR_REL) ||
                      (state_q == S_RD)  || (state_q == S_RD_REL);
    assign in_run   = (state_q == S_FETCH) || (state_q == S_RD) || (state_q == S_RD_REL);

    // Next-state, handshake, sample timer and output decode
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        per_d      = per_q;
        tmr_d      = tmr_q;
        fetched_d  = fetched_q;
        played_d   = played_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        underrun_d = underrun_q;
        to_err_d   = to_err_q;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        tick       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    len_d      = play_len;
                    per_d      = (period < DIV_W'(2)) ? DIV_W'(2) : period;
                    fetched_d  = '0;
                    played_d   = '0;
                    underrun_d = 1'b0;
                    to_err_d   = 1'b0;
                    flush      = 1'b1;
                    state_d    = S_CLR;
                end
            end
            S_CLR: if (rbp_ack) state_d = S_CLR_REL;
            S_CLR_REL: begin
                if (!rbp_ack) begin
                    if (len_q == '0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        tmr_d   = per_q - DIV_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if ((fetched_q < len_q) && (fifo_cnt_q < CNT_W'(DEPTH))) begin
                    state_d = S_RD;
                end else if (played_q == len_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (rbp_ack) begin
                    push      = 1'b1;
                    fetched_d = fetched_q + LEN_W'(1);
                    state_d   = S_RD_REL;
                end
            end
            S_RD_REL: if (!rbp_ack) state_d = S_FETCH;
            S_ABORT: begin
                flush   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A phase stuck for TIMEOUT cycles aborts the transaction
        if (in_phase && (state_d == state_q) && (to_q == TO_W'(TIMEOUT - 1))) begin
            to_err_d = 1'b1;
            state_d  = S_ABORT;
        end
        if (stop && (state_q != S_IDLE) && (state_q != S_ABORT)) begin
            push      = 1'b0;
            fetched_d = fetched_q;
            done_d    = 1'b0;
            state_d   = S_ABORT;
        end
        to_d = (in_phase && (state_d == state_q)) ? to_q + TO_W'(1) : '0;

        if (in_run) begin
            if (tmr_q == '0) begin
                tick  = 1'b1;
                tmr_d = per_q - DIV_W'(1);
            end else begin
                tmr_d = tmr_q - DIV_W'(1);
            end
        end
        if (tick && (state_d != S_ABORT)) begin
            if (fifo_cnt_q != '0) begin
                pop      = 1'b1;
                sample_d = mem_q[rd_ptr_q];
                valid_d  = 1'b1;
                played_d = played_q + LEN_W'(1);
            end else if (played_q < len_q) begin
                underrun_d = 1'b1;
            end
        end

        req_d     = (state_d == S_CLR) || (state_d == S_RD);
        cmd_d     = ((state_d == S_RD) || (state_d == S_RD_REL)) ? 4'd1 : 4'd0;
        rst_d     = (state_d == S_ABORT);
        playing_d = ((state_d != S_IDLE) && (state_d != S_ABORT)) || done_d;
    end

    // State, counters and registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            per_q      <= '0;
            tmr_q      <= '0;
            to_q       <= '0;
            fetched_q  <= '0;
            played_q   <= '0;
            req_q      <= 1'b0;
            cmd_q      <= '0;
            rst_q      <= 1'b0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            playing_q  <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            to_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            per_q      <= per_d;
            tmr_q      <= tmr_d;
            to_q       <= to_d;
            fetched_q  <= fetched_d;
            played_q   <= played_d;
            req_q      <= req_d;
            cmd_q      <= cmd_d;
            rst_q      <= rst_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            playing_q  <= playing_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            to_err_q   <= to_err_d;
        end
    end

    // Sample FIFO; push only from RD, which is entered with room to spare
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= rbp_data;
                wr_ptr_q        <= wr_ptr_q + FIFO_AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
            else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rbp_sample_player.sv
// Directed bench for rbp_sample_player: behavioural rbp slave with programmable ack
// latency, negedge monitor, and hand-computed expectations.
module tb_rbp_sample_player;

    localparam int unsigned TO = 64;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n, start, stop, rbp_ack, rbp_req, rbp_rst, rbp_dat;
    logic [23:0] play_len;
    logic [15:0] period, rbp_data, sample_out;
    logic [3:0]  rbp_cmd;
    logic        sample_valid, playing, done, underrun, timeout_err;

    rbp_sample_player #(.DIV_W(16), .FIFO_AW(2), .TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .stop(stop),
        .play_len(play_len), .period(period), .rbp_req(rbp_req), .rbp_ack(rbp_ack),
        .rbp_rst(rbp_rst), .rbp_dat(rbp_dat), .rbp_cmd(rbp_cmd), .rbp_data(rbp_data),
        .sample_out(sample_out), .sample_valid(sample_valid), .playing(playing),
        .done(done), .underrun(underrun), .timeout_err(timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // rbp slave: acks s_lat cycles after req, returns 0x1000 + read index
    int unsigned s_lat = 3, s_wait = 0;
    bit          s_rd_en = 1'b1;
    logic [15:0] s_idx = '0;
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            rbp_ack = 1'b0;
            s_wait  = 0;
        end else if (rbp_req && !rbp_ack) begin
            s_wait++;
            if (s_wait >= s_lat && (rbp_cmd == 4'd0 || s_rd_en)) begin
                rbp_ack = 1'b1;
                s_wait  = 0;
                if (rbp_cmd == 4'd0) begin
                    s_idx = '0;
                end else begin
                    rbp_data = 16'h1000 + s_idx;
                    s_idx++;
                end
            end
        end else if (!rbp_req) begin
            rbp_ack = 1'b0;
            s_wait  = 0;
        end
    end

    int unsigned cyc = 0, clr_txn = 0, rd_txn = 0, done_cnt = 0, rst_hi = 0;
    int unsigned glitch = 0, req_run = 0, last_run = 0;
    logic [15:0] vdat[$];
    int unsigned vcyc[$];
    logic        prev_req = 1'b0;
    logic [15:0] prev_so = '0;
    always @(negedge sys_clk) begin
        cyc++;
        if (rbp_req && !prev_req) begin
            if (rbp_cmd == 4'd0) clr_txn++;
            else rd_txn++;
        end
        if (rbp_req) req_run++;
        else begin
            if (req_run != 0) last_run = req_run;
            req_run = 0;
        end
        prev_req = rbp_req;
        if (sample_valid) begin
            vdat.push_back(sample_out);
            vcyc.push_back(cyc);
        end else if (sample_out !== prev_so) begin
            glitch++;
        end
        prev_so = sample_out;
        if (done) done_cnt++;
        if (rbp_rst) rst_hi++;
    end

    int unsigned b_clr, b_rd, b_v, b_done, b_rst, b_gl;

    task automatic snap();
        b_clr = clr_txn; b_rd = rd_txn; b_v = vdat.size();
        b_done = done_cnt; b_rst = rst_hi; b_gl = glitch;
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(negedge sys_clk);
        #1;
    endtask

    task automatic start_play(input logic [23:0] len, input logic [15:0] per);
        play_len = len;
        period   = per;
        start    = 1'b1;
        step(1);
        start    = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while (playing && n < budget) begin
            step(1);
            n++;
        end
        chk({tag, "_finished"}, 32'(playing), 32'd0);
    endtask

    task automatic chk_data(input string tag, input int unsigned cnt);
        for (int unsigned i = 0; i < cnt; i++) begin
            chk(tag, (b_v + i < vdat.size()) ? 32'(vdat[b_v + i]) : 32'hDEAD_BEEF,
                32'h1000 + i);
        end
    endtask

    initial begin
        int unsigned n;
        sys_rst_n = 1'b0; start = 1'b0; stop = 1'b0; play_len = '0; period = '0;
        rbp_ack = 1'b0; rbp_data = '0;
        step(2);
        chk("rst_req", 32'(rbp_req), 32'd0);
        chk("rst_cmd", 32'(rbp_cmd), 32'd0);
        chk("rst_outs", {26'd0, rbp_rst, rbp_dat, sample_valid, playing, done, underrun}, 32'd0);
        chk("rst_sample", 32'(sample_out), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        sys_rst_n = 1'b1;
        step(1);

        // Normal playback
        s_lat = 3; snap();
        start_play(24'd5, 16'd10);
        wait_idle("t1", 2000);
        chk("t1_clr_txn", clr_txn - b_clr, 32'd1);
        chk("t1_rd_txn", rd_txn - b_rd, 32'd5);
        chk("t1_nvalid", vdat.size() - b_v, 32'd5);
        chk_data("t1_data", 5);
        for (int unsigned i = 1; i < 5; i++)
            chk("t1_spacing", (b_v + i < vcyc.size()) ? vcyc[b_v + i] - vcyc[b_v + i - 1] : 0, 32'd10);
        chk("t1_done", done_cnt - b_done, 32'd1);
        chk("t1_underrun", 32'(underrun), 32'd0);
        chk("t1_timeout", 32'(timeout_err), 32'd0);

        // Slow slave
        s_lat = 25; snap();
        start_play(24'd4, 16'd8);
        wait_idle("t2", 3000);
        chk("t2_underrun", 32'(underrun), 32'd1);
        chk("t2_nvalid", vdat.size() - b_v, 32'd4);
        chk_data("t2_data", 4);
        chk("t2_hold", glitch - b_gl, 32'd0);
        chk("t2_done", done_cnt - b_done, 32'd1);

        // FIFO full stall
        s_lat = 1; snap();
        start_play(24'd10, 16'd100);
        step(40);
        chk("t3_fifo_full", 32'(dut.fifo_cnt_q), 32'd4);
        chk("t3_rd_stall", rd_txn - b_rd, 32'd4);
        chk("t3_req_low", 32'(rbp_req), 32'd0);
        n = 0;
        while (!sample_valid && n < 200) begin step(1); n++; end
        chk("t3_first_valid", 32'(sample_valid), 32'd1);
        chk("t3_no_req_before_pop", rd_txn - b_rd, 32'd4);
        step(3);
        chk("t3_refetch", rd_txn - b_rd, 32'd5);
        chk("t3_refill", 32'(dut.fifo_cnt_q), 32'd4);
        wait_idle("t3", 2000);
        chk("t3_nvalid", vdat.size() - b_v, 32'd10);
        chk_data("t3_data", 10);
        chk("t3_underrun", 32'(underrun), 32'd0);

        // Handshake timeout during RD
        s_lat = 2; s_rd_en = 1'b0; snap();
        start_play(24'd3, 16'd10);
        n = 0;
        while (!rbp_rst && n < 500) begin step(1); n++; end
        chk("t4_rst_seen", 32'(rbp_rst), 32'd1);
        chk("t4_req_len", last_run, TO);
        step(1);
        chk("t4_rst_pulse", rst_hi - b_rst, 32'd1);
        chk("t4_timeout_err", 32'(timeout_err), 32'd1);
        chk("t4_playing", 32'(playing), 32'd0);
        chk("t4_no_done", done_cnt - b_done, 32'd0);
        s_rd_en = 1'b1; snap();
        start_play(24'd2, 16'd10);
        chk("t4_err_cleared", 32'(timeout_err), 32'd0);
        wait_idle("t4b", 1000);
        chk("t4_new_clear", clr_txn - b_clr, 32'd1);
        chk("t4_nvalid", vdat.size() - b_v, 32'd2);
        chk_data("t4_data", 2);
        chk("t4_done", done_cnt - b_done, 32'd1);

        // stop mid-read with words buffered
        s_lat = 5; snap();
        start_play(24'd5, 16'd100);
        n = 0;
        while (!(rbp_req && rbp_cmd == 4'd1 && dut.fifo_cnt_q == 3'd2) && n < 200) begin
            step(1); n++;
        end
        chk("t5_in_read", 32'(rbp_req), 32'd1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("t5_rst", 32'(rbp_rst), 32'd1);
        chk("t5_req", 32'(rbp_req), 32'd0);
        step(1);
        chk("t5_flush", 32'(dut.fifo_cnt_q), 32'd0);
        chk("t5_playing", 32'(playing), 32'd0);
        step(200);
        chk("t5_no_valid", vdat.size() - b_v, 32'd0);
        chk("t5_no_done", done_cnt - b_done, 32'd0);
        snap();
        play_len = 24'd3; period = 16'd10; start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        step(10);
        chk("t5_startstop_idle", 32'(playing), 32'd0);
        chk("t5_startstop_clr", clr_txn - b_clr, 32'd0);

        // Zero-length playback
        s_lat = 2; snap();
        start_play(24'd0, 16'd5);
        wait_idle("t6", 200);
        chk("t6_clr_txn", clr_txn - b_clr, 32'd1);
        chk("t6_rd_txn", rd_txn - b_rd, 32'd0);
        chk("t6_nvalid", vdat.size() - b_v, 32'd0);
        chk("t6_done", done_cnt - b_done, 32'd1);

        // Asynchronous reset mid-RD
        s_lat = 10;
        start_play(24'd3, 16'd10);
        n = 0;
        while (!(rbp_req && rbp_cmd == 4'd1) && n < 100) begin step(1); n++; end
        chk("t7_in_read", 32'(rbp_req), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        chk("t7_req_async", 32'(rbp_req), 32'd0);
        chk("t7_playing_async", 32'(playing), 32'd0);
        step(2);
        sys_rst_n = 1'b1;
        step(2);
        chk("t7_idle_after", 32'(playing), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
